// File: rtl/hello_pkg.sv
// Shared state encoding and message ROM for the "Hello, world!" UART transmitter.
package hello_pkg;

   localparam int MSG_LEN = 15;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   function automatic logic [7:0] msg_byte(input logic [3:0] idx);
      logic [7:0] b;
      case (idx)
         4'd0:    b = 8'h48;
         4'd1:    b = 8'h65;
         4'd2:    b = 8'h6C;
         4'd3:    b = 8'h6C;
         4'd4:    b = 8'h6F;
         4'd5:    b = 8'h2C;
         4'd6:    b = 8'h20;
         4'd7:    b = 8'h77;
         4'd8:    b = 8'h6F;
         4'd9:    b = 8'h72;
         4'd10:   b = 8'h6C;
         4'd11:   b = 8'h64;
         4'd12:   b = 8'h21;
         4'd13:   b = 8'h0D;
         4'd14:   b = 8'h0A;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/hello_uart_tx_if.sv
// Control/status bundle between the message transmitter and its host.
interface hello_uart_tx_if;
   logic       start;
   logic       repeat_en;
   logic       tx;
   logic       busy;
   logic [3:0] char_idx;
   logic       done;

   modport master (output start, repeat_en, input tx, busy, char_idx, done);
   modport slave  (input start, repeat_en, output tx, busy, char_idx, done);
endinterface

// File: rtl/hello_baud_tick.sv
// Bit-period timer: tick marks the last cycle of every CLKS_PER_BIT-cycle period.
module hello_baud_tick #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);
   localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || tick) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/hello_uart_tx.sv
// Streams "Hello, world!\r\n" as back-to-back 8N1 frames, optionally repeating.
module hello_uart_tx
   import hello_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic            clk,
   input  logic            rst,
   hello_uart_tx_if.slave  bus
);
   localparam logic [3:0] LAST_CHAR = 4'(MSG_LEN - 1);

   state_t     state_q, state_d;
   logic [3:0] char_q, char_d;
   logic [2:0] bit_q, bit_d;
   logic       tx_q, tx_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [3:0] char_idx_q, char_idx_d;
   logic [7:0] cur_byte;
   logic       tick, clear;

   hello_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .tick  (tick)
   );

   always_comb begin
      state_d  = state_q;
      char_d   = char_q;
      bit_d    = bit_q;
      cur_byte = msg_byte(char_q);
      case (state_q)
         IDLE:  if (bus.start) begin
                   state_d = START;
                   char_d  = '0;
                end
         START: if (tick) begin
                   state_d = DATA;
                   bit_d   = '0;
                end
         DATA:  if (tick) begin
                   bit_d = bit_q + 3'd1;
                   if (bit_q == 3'd7) state_d = STOP;
                end
         STOP:  if (tick) begin
                   if (char_q != LAST_CHAR) begin
                      char_d  = char_q + 4'd1;
                      state_d = START;
                   end else begin
                      char_d  = '0;
                      state_d = bus.repeat_en ? START : IDLE;
                   end
                end
         default: state_d = IDLE;
      endcase

      // counter is held at zero while idle and restarts on every state entry
      clear = (state_q == IDLE) || (state_d != state_q);

      // outputs follow the current state one register stage later, so all
      // timing relations between them are preserved
      tx_d       = (state_q == START) ? 1'b0 :
                   (state_q == DATA)  ? cur_byte[bit_q] : 1'b1;
      busy_d     = (state_q != IDLE);
      done_d     = busy_q && (state_q == IDLE);
      char_idx_d = char_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         char_q     <= '0;
         bit_q      <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         char_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         char_q     <= char_d;
         bit_q      <= bit_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         char_idx_q <= char_idx_d;
      end
   end

   assign bus.tx       = tx_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.char_idx = char_idx_q;
endmodule

// File: tb/tb_hello_uart_tx.sv
// Bench for hello_uart_tx: first-frame vector table, directed corner cases and
// randomized repeat bursts compared against a message-level model.
module tb_hello_uart_tx;
   localparam int CA = 4;
   localparam int CB = 1;
   localparam int MLEN = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hello_uart_tx_if bus_a ();
   hello_uart_tx_if bus_b ();

   hello_uart_tx #(.CLKS_PER_BIT(CA)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   hello_uart_tx #(.CLKS_PER_BIT(CB)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   logic start_v [2];
   logic rep_v   [2];
   assign bus_a.start     = start_v[0];
   assign bus_a.repeat_en = rep_v[0];
   assign bus_b.start     = start_v[1];
   assign bus_b.repeat_en = rep_v[1];

   string msg = "Hello, world!\r\n";

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // {done, tx, busy, char_idx}
   function automatic logic [6:0] outs(input int id);
      if (id == 0) return {bus_a.done, bus_a.tx, bus_a.busy, bus_a.char_idx};
      return {bus_b.done, bus_b.tx, bus_b.busy, bus_b.char_idx};
   endfunction

   // UART monitor / activity counters, sampled on the falling edge
   int         cyc = 0;
   int         mcnt [2];
   bit         mact [2];
   logic [7:0] msh [2];
   logic       pbusy [2];
   int         busy_cnt [2];
   int         done_cnt [2];
   logic [7:0] rx0 [$];
   logic [7:0] rx1 [$];
   int         st0 [$];
   int         st1 [$];
   logic [6:0] mo;
   int         mc;

   task automatic clr_mon();
      for (int i = 0; i < 2; i++) begin
         busy_cnt[i] = 0;
         done_cnt[i] = 0;
      end
      rx0.delete(); rx1.delete(); st0.delete(); st1.delete();
   endtask

   always @(negedge clk) begin
      for (int id = 0; id < 2; id++) begin
         mo = outs(id);
         mc = (id == 0) ? CA : CB;
         if (rst) begin
            mact[id]  = 1'b0;
            pbusy[id] = 1'b0;
         end else begin
            busy_cnt[id] += int'(mo[4]);
            if (mo[6]) begin
               done_cnt[id]++;
               chk("done_at_busy_fall", {30'd0, pbusy[id], mo[4]}, 32'd2);
            end
            pbusy[id] = mo[4];
            if (!mact[id]) begin
               if (!mo[5]) begin
                  mact[id] = 1'b1;
                  mcnt[id] = 0;
                  if (id == 0) st0.push_back(cyc); else st1.push_back(cyc);
               end
            end else begin
               mcnt[id]++;
               if (mcnt[id] >= mc && mcnt[id] < 9*mc && (mcnt[id] - mc) % mc == mc/2)
                  msh[id][(mcnt[id] - mc) / mc] = mo[5];
               if (mcnt[id] == 9*mc + mc/2) begin
                  chk("stop_bit", {31'd0, mo[5]}, 32'd1);
                  if (id == 0) rx0.push_back(msh[id]); else rx1.push_back(msh[id]);
               end
               if (mcnt[id] == 10*mc - 1) mact[id] = 1'b0;
            end
         end
      end
      cyc++;
   end

   logic [6:0] trace [64];

   // Sends r messages: start pulse, repeat_en held for r-1 boundaries. With rnd,
   // repeat_en is random except at message boundaries and start is hammered
   // while busy. poke adds one extra start pulse at that sample.
   task automatic run_burst(input int id, input int r, input bit rnd, input int poke);
      int c, per, n, nbad, lim;
      logic [6:0] o;
      logic [7:0] rx [$];
      int st [$];
      c = (id == 0) ? CA : CB;
      per = 150 * c;
      n = per * r;
      clr_mon();
      @(negedge clk);
      start_v[id] = 1'b1;
      rep_v[id]   = (r > 1);
      for (int j = 1; j <= n + 20; j++) begin
         @(negedge clk);
         if (j <= 64) trace[j-1] = outs(id);
         start_v[id] = (j < n) && ((rnd && $urandom_range(0, 7) == 0) || j == poke);
         if (j % per == 0)  rep_v[id] = (j / per < r);
         else if (rnd)      rep_v[id] = 1'($urandom_range(0, 1));
         else               rep_v[id] = (j < per * (r - 1));
      end
      rep_v[id] = 1'b0;
      chk("busy_cycles", busy_cnt[id], n);
      chk("done_count", done_cnt[id], 1);
      o = outs(id);
      chk("end_tx", {31'd0, o[5]}, 32'd1);
      chk("end_busy", {31'd0, o[4]}, 32'd0);
      chk("end_char_idx", {28'd0, o[3:0]}, 32'd0);
      if (id == 0) begin rx = rx0; st = st0; end
      else         begin rx = rx1; st = st1; end
      chk("byte_count", rx.size(), MLEN * r);
      lim = (rx.size() < MLEN * r) ? rx.size() : MLEN * r;
      for (int i = 0; i < lim; i++) chk("rx_byte", rx[i], msg[i % MLEN]);
      nbad = 0;
      for (int i = 1; i < st.size(); i++) if (st[i] - st[i-1] != 10 * c) nbad++;
      chk("frame_gaps", nbad, 0);
   endtask

   typedef struct {
      int         k;
      logic       tx;
      logic       busy;
      logic [3:0] idx;
   } vec_t;

   vec_t       tbl [17];
   logic [6:0] o;
   int         r;

   initial begin
      // first frame of 'H' (0x48) at 4 clocks/bit, sample k = k-th falling edge after the start edge
      tbl = '{
         '{0,  1'b1, 1'b0, 4'd0}, '{1,  1'b0, 1'b1, 4'd0}, '{4,  1'b0, 1'b1, 4'd0},
         '{5,  1'b0, 1'b1, 4'd0}, '{6,  1'b0, 1'b1, 4'd0}, '{10, 1'b0, 1'b1, 4'd0},
         '{14, 1'b0, 1'b1, 4'd0}, '{17, 1'b1, 1'b1, 4'd0}, '{18, 1'b1, 1'b1, 4'd0},
         '{20, 1'b1, 1'b1, 4'd0}, '{21, 1'b0, 1'b1, 4'd0}, '{26, 1'b0, 1'b1, 4'd0},
         '{30, 1'b1, 1'b1, 4'd0}, '{34, 1'b0, 1'b1, 4'd0}, '{37, 1'b1, 1'b1, 4'd0},
         '{40, 1'b1, 1'b1, 4'd0}, '{41, 1'b0, 1'b1, 4'd1}
      };
      start_v = '{1'b0, 1'b0};
      rep_v   = '{1'b0, 1'b0};

      repeat (3) @(negedge clk);
      for (int id = 0; id < 2; id++) begin
         o = outs(id);
         chk("rst_tx", {31'd0, o[5]}, 32'd1);
         chk("rst_busy_done", {30'd0, o[6], o[4]}, 32'd0);
         chk("rst_char_idx", {28'd0, o[3:0]}, 32'd0);
      end
      #2 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", {25'd0, outs(0)}, 32'h20);

      run_burst(0, 1, 1'b0, -1);
      foreach (tbl[i]) begin
         chk("tbl_tx",   {31'd0, trace[tbl[i].k][5]},   {31'd0, tbl[i].tx});
         chk("tbl_busy", {31'd0, trace[tbl[i].k][4]},   {31'd0, tbl[i].busy});
         chk("tbl_idx",  {28'd0, trace[tbl[i].k][3:0]}, {28'd0, tbl[i].idx});
      end

      run_burst(0, 1, 1'b0, 50);
      run_burst(0, 2, 1'b0, -1);

      // asynchronous reset in the data bits of the third byte
      @(negedge clk); start_v[0] = 1'b1;
      @(negedge clk); start_v[0] = 1'b0;
      repeat (95) @(negedge clk);
      o = outs(0);
      chk("pre_rst_idx", {28'd0, o[3:0]}, 32'd2);
      chk("pre_rst_busy", {31'd0, o[4]}, 32'd1);
      #3 rst = 1'b1;
      #1 o = outs(0);
      chk("async_rst_tx", {31'd0, o[5]}, 32'd1);
      chk("async_rst_busy", {31'd0, o[4]}, 32'd0);
      chk("async_rst_idx", {28'd0, o[3:0]}, 32'd0);
      chk("async_rst_done", {31'd0, o[6]}, 32'd0);
      #17 rst = 1'b0;
      run_burst(0, 1, 1'b0, -1);

      run_burst(1, 1, 1'b0, -1);

      for (int it = 0; it < 3; it++) begin
         r = $urandom_range(1, 3);
         run_burst(1, r, 1'b1, -1);
         r = $urandom_range(1, 3);
         run_burst(0, r, 1'b1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hello_uart_tx.md
# hello_uart_tx

UART transmitter that streams the fixed ASCII message "Hello, world!\r\n" (15 bytes) as 8N1 frames. The block is instantiated inside the tt_um_test top wrapper, and its serial line drives a dedicated output pin. The top wrapper maps the pins as follows: ui_in[0] to start, ui_in[1] to repeat_en, tx to uo_out[0], busy to uo_out[1], char_idx to uo_out[5:2]. The wrapper derives rst from the pin-level reset as rst = ~rst_n.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per UART bit (434 gives 115200 baud at 50 MHz). Legal range is 1..65535.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request to send one message; sampled only in IDLE.
- repeat_en  input  1  when high at the end of a message, the message is restarted with no gap.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while any frame is in progress.
- char_idx  output  4  index of the byte currently being sent (0..14); 0 when idle.
- done  output  1  one-cycle pulse when a message completes and no repeat follows.

## Operation
- FSM states are IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If start=1 on a clock edge, go to START with char_idx=0.
  - start is level-sampled, so holding it high in IDLE re-triggers only after done.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA:
  - tx = msg[char_idx][bit_idx], sent LSB first.
  - Each bit is held for CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the end of STOP:
  - If char_idx<14: increment char_idx and go to START.
  - If char_idx==14 and repeat_en=1: set char_idx=0 and go to START.
  - If char_idx==14 and repeat_en=0: go to IDLE, pulse done, set char_idx=0.
- start is ignored outside IDLE.
- Changes on repeat_en matter only at the final STOP boundary.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - It is cleared on every state entry.
  - A bit ends when counter==CLKS_PER_BIT-1.
  - Counter width is max(1, $clog2(CLKS_PER_BIT)) bits.
- The message bytes are, in order: 0x48 65 6C 6C 6F 2C 20 77 6F 72 6C 64 21 0D 0A.
- Reset, including mid-frame, asynchronously forces:
  - state=IDLE, tx=1, busy=0, done=0, char_idx=0, and all counters 0.
  - A partial frame is simply truncated.
- All outputs are registered. No combinational path from any input to any output.

## Timing
- tx falls on the first edge after the edge at which start=1 is sampled in IDLE. busy rises on the same edge.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Consecutive bytes are back-to-back, with no idle cycles between a stop bit and the next start bit.
- A full message takes 150*CLKS_PER_BIT cycles from the falling edge of tx to the fall of busy.
- done is high for exactly one cycle, coincident with the cycle in which busy first reads 0.
- When repeat_en=1 at the end of a message:
  - busy stays high.
  - done does not pulse.
  - The next start bit begins on the cycle after the last stop bit ends.
- CLKS_PER_BIT=1 is legal: every bit lasts one cycle.

## Structure
- Package hello_pkg holds:
  - MSG_LEN=15.
  - The state enum (IDLE, START, DATA, STOP).
  - The function msg_byte(idx), a 15-entry ROM with default 0x00.
- Sub-module hello_baud_tick, parameterised by CLKS_PER_BIT, with inputs clk, rst and clear.
  - It produces tick, a one-cycle pulse every CLKS_PER_BIT cycles after clear.
  - The FSM uses tick to end each bit period.
- The top level holds the FSM, char_idx, bit_idx, and the tx/busy/done registers.

## Test plan
- Single byte check:
  - Stimulus: CLKS_PER_BIT=4, one-cycle start pulse.
  - Required: tx=0 for 4 cycles, then bits 0,0,0,1,0,0,1,0 (0x48) at 4 cycles each, then tx=1 for 4 cycles; char_idx then reads 1.
- Full message:
  - Stimulus: CLKS_PER_BIT=4, repeat_en=0.
  - Required: a UART monitor decodes "Hello, world!\r\n"; busy stays high for exactly 600 cycles; done pulses once; tx=1 afterwards.
- Start while busy:
  - Stimulus: pulse start again 50 cycles into the message.
  - Required: no effect; total busy time is still 600 cycles; single done.
- Repeat:
  - Stimulus: repeat_en=1, CLKS_PER_BIT=4.
  - Required: the monitor sees the message twice back-to-back (30 bytes, no gap); no done between them.
  - Then drop repeat_en: exactly one done, after byte 30.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously, not aligned to clk, during DATA of byte 3.
  - Required: tx=1, busy=0, char_idx=0 immediately; after release, a new start sends from 'H'.
- Edge parameter:
  - Stimulus: CLKS_PER_BIT=1.
  - Required: message completes in 150 cycles and decodes correctly.
